// File: rtl/seq_addsub.sv
// seq_addsub: chunked LSB-first multi-cycle add/subtract with button-loaded operands
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       btn,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] a, b, wa, wb, res, nres;
  logic [CHUNK:0]   part;
  logic [CW-1:0]    cnt;
  logic             c, sa, sb, last;
  assign busy = state == RUN;
  assign done = state == DONE;
  // chunk adder and the result register as it will look after this chunk is shifted in at the top
  always_comb begin
    part = {1'b0, wa[CHUNK-1:0]} + {1'b0, wb[CHUNK-1:0]} + (CHUNK+1)'(c);
    nres = (res >> CHUNK) | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
    last = cnt == CW'(N - 1);
  end
  // operand registers load from the switch bus whenever their button is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else begin
      if (btn[0]) a <= sw;
      if (btn[1]) b <= sw;
    end
  end
  // sequencer: snapshot operands on start, add one chunk per RUN cycle, publish results on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wa    <= '0;
      wb    <= '0;
      res   <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (state != RUN && start) begin
      wa    <= a;
      wb    <= mode ? ~b : b;
      c     <= mode;
      cnt   <= '0;
      sa    <= a[WIDTH-1];
      sb    <= mode ? ~b[WIDTH-1] : b[WIDTH-1];
      state <= RUN;
    end else if (state == RUN) begin
      res <= nres;
      c   <= part[CHUNK];
      wa  <= wa >> CHUNK;
      wb  <= wb >> CHUNK;
      cnt <= cnt + CW'(1);
      if (last) begin
        state <= DONE;
        sum   <= nres;
        carry <= part[CHUNK];
        ovf   <= (sa == sb) && (nres[WIDTH-1] != sa);
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit; successor of the switch-loaded 4-bit ripple adder.
- Operands A and B are captured from the switch bus by button strobes.
- A start pulse launches a chunked, LSB-first add or subtract over WIDTH/CHUNK cycles with a busy/done handshake.
- Result, carry/no-borrow and signed overflow are held until the next operation; sits between board I/O (switches/buttons) and display logic.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per RUN cycle (1 = bit-serial, CHUNK = WIDTH = single-cycle).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  operand data bus.
- btn  input  2  btn[0] loads A from sw; btn[1] loads B from sw; level-sampled each clock.
- start  input  1  launches an operation; sampled in IDLE or DONE only.
- mode  input  1  0 = A+B, 1 = A-B; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result register.
- carry  output  1  carry-out for add; no-borrow (carry out of A + ~B + 1) for subtract.
- ovf  output  1  two's-complement signed overflow of the completed operation.

Behaviour:
- Reset (async, rst_n=0): A=0, B=0, sum=0, carry=0, ovf=0, busy=0, done=0, state=IDLE, chunk counter=0. Takes effect immediately; an operation in progress is aborted and no done is issued.
- Operand registers: btn[0] loads A<=sw and btn[1] loads B<=sw on any clock edge, in any state. Both buttons high loads both with the same value.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Copy A into working register WA and B into WB (WB inverted when mode=1).
  - Latch mode; set running carry c=mode; counter=0; go to RUN.
  - Operands are copied from the register values before any same-edge btn load; a load in the start cycle affects only the next operation.
- RUN, each cycle:
  - Add chunk k: WA[CHUNK-1:0] + WB[CHUNK-1:0] + c; write the partial result into the result shift register; update c.
  - Shift WA and WB right by CHUNK; counter++.
  - On the last chunk (counter = WIDTH/CHUNK-1), go to DONE.
- Entering DONE:
  - sum <= assembled result; carry <= final c.
  - ovf <= (sign of A == sign of effective B) && (sign of sum != sign of A), using the operand copies taken at start.
  - done=1 for exactly one cycle.
- DONE with no start: return to IDLE next cycle. DONE with start: begin a new operation directly (back-to-back).
- Latency: start sampled at edge 0; busy high for cycles 1..WIDTH/CHUNK; done high in cycle WIDTH/CHUNK+1 (5 for the defaults).
- start while busy is ignored (no queuing). mode is ignored except in the start cycle.
- sum, carry and ovf change only on entry to DONE or on reset. Partial results are never visible on the outputs.
- Wrap-around: results are modulo 2^WIDTH; the carry bit reports the overflow out of the MSB.

Test Plan (WIDTH=8, CHUNK=2):
- Add: btn[0] with sw=0x5A, btn[1] with sw=0x3C, start with mode=0 -> busy high 4 cycles, done in cycle 5; sum=0x96, carry=0, ovf=1.
- Subtract: A=0x10, B=0x20, mode=1 -> sum=0xF0, carry=0 (borrow), ovf=0. Then A=0x80, B=0x01, mode=1 -> sum=0x7F, carry=1, ovf=1.
- Wrap: A=0xFF, B=0x01, mode=0 -> sum=0x00, carry=1, ovf=0.
- Ignored start and in-flight load:
  - Start A=0x01, B=0x02.
  - Pulse start again in cycle 2 and load btn[0] with sw=0x77 in cycle 2.
  - -> exactly one done; sum=0x03; A register reads back 0x77 on the next op (0x77+0x02 -> 0x79).
- Load-and-start same edge: A=0x05, B=0x05; on the start edge assert btn[0] with sw=0x10 -> sum=0x0A; next start -> 0x15.
- Reset mid-run: rst_n low in cycle 2 of an op -> busy=0, done never pulses, sum=0 and carry=0 immediately. After release, a new op 0x03+0x04 -> 0x07.
